// File: rtl/trace_pkg.sv
// Shared definitions for the trace UART transmit buffer.
//   TRACE_FIFO_DEPTH : default number of queued bytes
//   BUSY_TIMEOUT     : BUSY cycles with the UART still reporting idle before
//                      the start is assumed to have been accepted anyway
//   drain_state_t    : states of the drain sequencer
package trace_pkg;

    localparam int TRACE_FIFO_DEPTH = 16;
    localparam int BUSY_TIMEOUT     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } drain_state_t;

endpackage

// File: rtl/trace_tx_fifo_if.sv
// Bus between the MMIO trace path / UART TX and the trace transmit buffer.
//   wr_data_i, wr_valid_i, wr_ready_o : byte enqueue path
//   flush_i, clr_ovf_i                : queue discard / overflow clear strobes
//   level_o, empty_o, overflow_o      : status register fields
//   uart_data_o, uart_start_o,
//   uart_done_i                       : UART TX start/done handshake
//   dbg_state                         : current drain sequencer state
// Modports: master = producer/UART side, slave = buffer side.
//
// Handshakes: a byte is enqueued on every clock edge where wr_valid_i and
// wr_ready_o are both high; wr_valid_i while wr_ready_o is low drops the byte
// and raises the sticky overflow flag (the producer is never stalled).
// wr_ready_o comes from the registered level only. On the UART side,
// uart_start_o is a single-cycle pulse issued only after uart_done_i was seen
// high; uart_data_o is stable from that pulse until the next one.
interface trace_tx_fifo_if
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       wr_data_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic             flush_i;
    logic             clr_ovf_i;
    logic [CNT_W-1:0] level_o;
    logic             empty_o;
    logic             overflow_o;
    logic [7:0]       uart_data_o;
    logic             uart_start_o;
    logic             uart_done_i;
    drain_state_t     dbg_state;

    modport master (
        output wr_data_i, wr_valid_i, flush_i, clr_ovf_i, uart_done_i,
        input  wr_ready_o, level_o, empty_o, overflow_o,
               uart_data_o, uart_start_o, dbg_state
    );

    modport slave (
        input  wr_data_i, wr_valid_i, flush_i, clr_ovf_i, uart_done_i,
        output wr_ready_o, level_o, empty_o, overflow_o,
               uart_data_o, uart_start_o, dbg_state
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy count and flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries, pointers back to zero (wins over push/pop)
//   push       : write push_data at the tail (caller guarantees not full)
//   pop        : advance the head (caller guarantees not empty)
//   head       : entry at the read pointer, combinational
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wptr] <= push_data;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/trace_tx_fifo.sv
// Trace transmit buffer: queues bytes from the MMIO trace register and feeds
// them one at a time to the UART transmitter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : enqueue path, flush / overflow-clear strobes, status
//                  (level, empty, sticky overflow) and the UART start/done
//                  handshake; see trace_tx_fifo_if
// The sync_fifo holds the bytes; this level owns the drain sequencer and
// the overflow flag.
module trace_tx_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_FIFO_DEPTH
) (
    input logic            clk_i,
    input logic            rst_i,
    trace_tx_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    drain_state_t     state, state_n;
    logic [1:0]       busy_cnt, busy_cnt_n;
    logic [CNT_W-1:0] count;
    logic [7:0]       head;
    logic [7:0]       data_q;
    logic             start_q;
    logic             overflow_q;
    logic             full, empty, push, pop, ovf_set;

    // Full comes from the registered count, so a same-cycle pop never
    // admits a write. A flush swallows a concurrent write silently.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.wr_valid_i && !full && !bus.flush_i;
    assign ovf_set = bus.wr_valid_i &&  full && !bus.flush_i;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (bus.flush_i),
        .push      (push),
        .push_data (bus.wr_data_i),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_cnt   <= '0;
            data_q     <= '0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_n;
            busy_cnt <= busy_cnt_n;
            start_q  <= pop;
            if (pop) data_q <= head;
            // Set wins over clear.
            if (ovf_set)            overflow_q <= 1'b1;
            else if (bus.clr_ovf_i) overflow_q <= 1'b0;
        end
    end

    // Pop happens only on IDLE->ISSUE; the head is latched on that edge so
    // the byte stays valid for the UART until the next ISSUE.
    always_comb begin
        state_n    = state;
        busy_cnt_n = '0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && bus.uart_done_i) begin
                    state_n = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: state_n = BUSY;
            BUSY: begin
                // A UART that never drops done (e.g. a very short frame
                // that was missed) must not wedge the sequencer.
                if (!bus.uart_done_i || busy_cnt == 2'(BUSY_TIMEOUT)) begin
                    state_n = DRAIN;
                end else begin
                    busy_cnt_n = busy_cnt + 2'd1;
                end
            end
            DRAIN: begin
                if (bus.uart_done_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.wr_ready_o   = !full;
    assign bus.level_o      = count;
    assign bus.empty_o      = empty;
    assign bus.overflow_o   = overflow_q;
    assign bus.uart_data_o  = data_q;
    assign bus.uart_start_o = start_q;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_trace_tx_fifo.sv
// Bench for trace_tx_fifo: scenario tasks with inline checks, a negedge
// monitor that also models the UART (busy for a fixed number of cycles after
// each start), and an expected-byte queue built from the enqueue rules.
module tb_trace_tx_fifo;
    import trace_pkg::*;

    localparam int DEPTH     = TRACE_FIFO_DEPTH;
    localparam int UART_BUSY = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    trace_tx_fifo_if #(.DEPTH(DEPTH)) bus();

    trace_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- UART model and output monitor ----------------
    logic       uart_auto  = 1'b0;
    logic       uart_force = 1'b1;
    logic       model_done = 1'b1;
    logic       prev_model_done = 1'b1;
    int         model_busy = 0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         start_while_busy = 0;
    int         gap_err = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    assign bus.uart_done_i = uart_auto ? model_done : uart_force;

    always @(negedge clk_i) begin
        cyc++;
        if (bus.uart_start_o) begin
            got_q.push_back(bus.uart_data_o);
            if (!bus.uart_done_i) start_while_busy++;
            if (rise_cyc >= 0 && (cyc - rise_cyc) < 2) gap_err++;
            rise_cyc = -1;
        end
        if (uart_auto && bus.uart_start_o) model_busy = UART_BUSY;
        else if (model_busy > 0)           model_busy--;
        model_done = (model_busy == 0);
        if (uart_auto && model_done && !prev_model_done) rise_cyc = cyc;
        prev_model_done = model_done;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        bus.clr_ovf_i  = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_data_i  = d;
        bus.wr_valid_i = 1'b1;
        tick();
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic wait_got(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_quiet(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.dbg_state == IDLE && bus.empty_o && bus.uart_done_i) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        bus.wr_data_i = 8'h00;
        uart_auto = 1'b0;
        uart_force = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        n_checks++; if (bus.level_o !== 0) $display("FAIL reset_level: got %0d want 0", bus.level_o); else n_pass++;
        n_checks++; if (bus.empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty_o); else n_pass++;
        n_checks++; if (bus.wr_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.wr_ready_o); else n_pass++;
        n_checks++; if (bus.overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.overflow_o); else n_pass++;
        n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL reset_start: got %b want 0", bus.uart_start_o); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.uart_data_o); else n_pass++;
        n_checks++; if (bus.dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); else n_pass++;
    endtask

    task automatic test_latency();
        bit ok;
        got_q.delete();
        write_byte(8'h41);
        // cycle N+1
        n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL lat_n1_start: got %b want 0", bus.uart_start_o); else n_pass++;
        n_checks++; if (bus.level_o !== 1) $display("FAIL lat_n1_level: got %0d want 1", bus.level_o); else n_pass++;
        tick();
        // cycle N+2
        n_checks++; if (bus.uart_start_o !== 1'b1) $display("FAIL lat_n2_start: got %b want 1", bus.uart_start_o); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h41) $display("FAIL lat_n2_data: got %h want 41", bus.uart_data_o); else n_pass++;
        n_checks++; if (bus.level_o !== 0) $display("FAIL lat_n2_level: got %0d want 0", bus.level_o); else n_pass++;
        tick();
        n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL lat_n3_start: got %b want 0", bus.uart_start_o); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h41) $display("FAIL lat_n3_hold: got %h want 41", bus.uart_data_o); else n_pass++;
        wait_quiet(50, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL lat_quiet: got timeout want idle"); else n_pass++;
        n_checks++; if (got_q.size() !== 1) $display("FAIL lat_count: got %0d want 1", got_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        got_q.delete();
        exp_q.delete();
        start_while_busy = 0;
        gap_err = 0;
        rise_cyc = -1;
        uart_auto = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            write_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        wait_got(3, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL b2b_timeout: got %0d starts want 3", got_q.size()); else n_pass++;
        wait_quiet(50, ok);
        n_checks++; if (got_q.size() !== 3) $display("FAIL b2b_count: got %0d want 3", got_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (start_while_busy !== 0) $display("FAIL b2b_start_busy: got %0d want 0", start_while_busy); else n_pass++;
        n_checks++; if (gap_err !== 0) $display("FAIL b2b_gap: got %0d short gaps want 0", gap_err); else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] d;
        logic model_ovf;
        uart_auto = 1'b0;
        uart_force = 1'b0;
        got_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom_range(0, 255));
            bus.wr_data_i = d;
            bus.wr_valid_i = 1'b1;
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else model_ovf = 1'b1;
            tick();
        end
        bus.wr_valid_i = 1'b0;
        n_checks++; if (bus.level_o !== exp_q.size()) $display("FAIL ovf_level: got %0d want %0d", bus.level_o, exp_q.size()); else n_pass++;
        n_checks++; if (bus.wr_ready_o !== (exp_q.size() < DEPTH)) $display("FAIL ovf_ready: got %b want 0", bus.wr_ready_o); else n_pass++;
        n_checks++; if (bus.overflow_o !== model_ovf) $display("FAIL ovf_flag: got %b want %b", bus.overflow_o, model_ovf); else n_pass++;
        // set and clear in one cycle: set wins
        bus.wr_valid_i = 1'b1;
        bus.clr_ovf_i = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (bus.overflow_o !== 1'b1) $display("FAIL ovf_set_prio: got %b want 1", bus.overflow_o); else n_pass++;
        bus.clr_ovf_i = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if (bus.overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", bus.overflow_o); else n_pass++;
        n_checks++; if (bus.level_o !== DEPTH) $display("FAIL ovf_level_kept: got %0d want %0d", bus.level_o, DEPTH); else n_pass++;
        // drain: only the first DEPTH bytes must come out
        uart_auto = 1'b1;
        wait_got(DEPTH, 600, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL ovf_drain_timeout: got %0d want %0d", got_q.size(), DEPTH); else n_pass++;
        wait_quiet(50, ok);
        n_checks++; if (got_q.size() !== DEPTH) $display("FAIL ovf_drain_count: got %0d want %0d", got_q.size(), DEPTH); else n_pass++;
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_flush();
        bit ok;
        uart_auto = 1'b0;
        uart_force = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom_range(0, 255)));
        n_checks++; if (bus.level_o !== DEPTH) $display("FAIL flush_fill: got %0d want %0d", bus.level_o, DEPTH); else n_pass++;
        // flush while full with a concurrent write
        bus.flush_i = 1'b1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'hEE;
        tick();
        idle_inputs();
        n_checks++; if (bus.level_o !== 0) $display("FAIL flush_level: got %0d want 0", bus.level_o); else n_pass++;
        n_checks++; if (bus.empty_o !== 1'b1) $display("FAIL flush_empty: got %b want 1", bus.empty_o); else n_pass++;
        n_checks++; if (bus.overflow_o !== 1'b0) $display("FAIL flush_ovf: got %b want 0", bus.overflow_o); else n_pass++;
        n_checks++; if (bus.wr_ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.wr_ready_o); else n_pass++;
        // flush while partly full, concurrent write also discarded
        write_byte(8'h10);
        write_byte(8'h20);
        bus.flush_i = 1'b1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'h77;
        tick();
        idle_inputs();
        n_checks++; if (bus.level_o !== 0) $display("FAIL flush_part_level: got %0d want 0", bus.level_o); else n_pass++;
        // only a fresh byte is sent afterwards
        got_q.delete();
        write_byte(8'h5A);
        uart_auto = 1'b1;
        wait_got(1, 50, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL flush_fresh_timeout: got %0d want 1", got_q.size()); else n_pass++;
        wait_quiet(50, ok);
        n_checks++; if (got_q.size() !== 1) $display("FAIL flush_fresh_count: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'h5A) $display("FAIL flush_fresh_data: got %h want 5a", got_q[0]); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] d;
        int sent;
        int guard;
        uart_auto = 1'b1;
        got_q.delete();
        exp_q.delete();
        start_while_busy = 0;
        sent = 0;
        guard = 0;
        // well-behaved producer: writes only when ready is visible
        while (sent < DEPTH * 3 && guard < 3000) begin
            if (bus.wr_ready_o && $urandom_range(0, 3) != 0) begin
                d = 8'($urandom_range(0, 255));
                bus.wr_data_i = d;
                bus.wr_valid_i = 1'b1;
                exp_q.push_back(d);
                sent++;
            end else begin
                bus.wr_valid_i = 1'b0;
            end
            tick();
            guard++;
        end
        bus.wr_valid_i = 1'b0;
        n_checks++; if (sent !== DEPTH * 3) $display("FAIL wrap_send_timeout: got %0d want %0d", sent, DEPTH * 3); else n_pass++;
        wait_got(sent, 1500, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL wrap_drain_timeout: got %0d want %0d", got_q.size(), sent); else n_pass++;
        wait_quiet(50, ok);
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (bus.level_o !== 0) $display("FAIL wrap_level: got %0d want 0", bus.level_o); else n_pass++;
        n_checks++; if (start_while_busy !== 0) $display("FAIL wrap_start_busy: got %0d want 0", start_while_busy); else n_pass++;
    endtask

    task automatic test_reset_busy();
        bit ok;
        bit found;
        uart_auto = 1'b1;
        got_q.delete();
        write_byte(8'h11);
        write_byte(8'h22);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dbg_state == BUSY) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (found !== 1'b1) $display("FAIL rstb_reach_busy: got state %0d want %0d", bus.dbg_state, BUSY); else n_pass++;
        rst_i = 1'b1;
        tick();
        n_checks++; if (bus.level_o !== 0) $display("FAIL rstb_level: got %0d want 0", bus.level_o); else n_pass++;
        n_checks++; if (bus.empty_o !== 1'b1) $display("FAIL rstb_empty: got %b want 1", bus.empty_o); else n_pass++;
        n_checks++; if (bus.uart_start_o !== 1'b0) $display("FAIL rstb_start: got %b want 0", bus.uart_start_o); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h00) $display("FAIL rstb_data: got %h want 00", bus.uart_data_o); else n_pass++;
        n_checks++; if (bus.dbg_state !== IDLE) $display("FAIL rstb_state: got %0d want %0d", bus.dbg_state, IDLE); else n_pass++;
        n_checks++; if (bus.wr_ready_o !== 1'b1) $display("FAIL rstb_ready: got %b want 1", bus.wr_ready_o); else n_pass++;
        rst_i = 1'b0;
        got_q.delete();
        write_byte(8'hC3);
        wait_got(1, 60, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rstb_fresh_timeout: got %0d want 1", got_q.size()); else n_pass++;
        wait_quiet(60, ok);
        n_checks++; if (got_q.size() !== 1) $display("FAIL rstb_fresh_count: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'hC3) $display("FAIL rstb_fresh_data: got %h want c3", got_q[0]); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        bus.wr_data_i = 8'h00;
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_wrap();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
